// File: rtl/burst_pkg.sv
// Shared constants, state encoding and beat payload for the single-to-burst write packer.
package burst_pkg;

  localparam int unsigned BURST_MAX  = 4;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = DATA_W / 8;
  localparam int unsigned IDX_W      = $clog2(BURST_MAX);
  localparam int unsigned CNT_W      = IDX_W + 1;
  localparam int unsigned BCNT_W     = 3;
  localparam int unsigned IDLE_W     = 8;
  localparam int unsigned WORD_LSB   = $clog2(WORD_BYTES);
  localparam int unsigned LINE_LSB   = $clog2(LINE_BYTES);
  localparam int unsigned WIDX_W     = LINE_LSB - WORD_LSB;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_READ    = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } beat_t;

  // A word at the start of a 16-byte line can never extend a burst begun in the previous line.
  function automatic logic is_line_head(input logic [WIDX_W-1:0] word_idx);
    return word_idx == '0;
  endfunction

endpackage

// File: rtl/burst_beat_buffer.sv
// Holds up to BURST_MAX collected write beats; one write port, one asynchronous read port.
module burst_beat_buffer
  import burst_pkg::*;
(
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  beat_t            wr_beat_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output beat_t            rd_beat_o
);

  beat_t beats_q [BURST_MAX];

  // Contents need no reset: the packer's beat count decides what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      beats_q[wr_idx_i] <= wr_beat_i;
    end
  end

  assign rd_beat_o = beats_q[rd_idx_i];

endmodule

// File: rtl/burst_packer.sv
// Coalesces consecutive single-beat Avalon-MM writes into bursts of up to four beats;
// reads are forwarded one at a time only after any collected writes have been flushed.
module burst_packer
  import burst_pkg::*;
#(
  parameter int unsigned IADDR   = 32,
  parameter int unsigned OADDR   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic [IADDR-1:0]  addr_in,
  input  logic              write_in,
  input  logic [DATA_W-1:0] writedata_in,
  input  logic [BE_W-1:0]   byteenable_in,
  input  logic              read_in,
  output logic [DATA_W-1:0] readdata_out,
  output logic              readdatavalid_out,
  output logic              waitrequest_out,
  output logic [OADDR-1:0]  addr_out,
  output logic [BCNT_W-1:0] burstcount_out,
  output logic              write_out,
  output logic [DATA_W-1:0] writedata_out,
  output logic [BE_W-1:0]   byteenable_out,
  output logic              read_out,
  input  logic [DATA_W-1:0] readdata_in,
  input  logic              readdatavalid_in,
  input  logic              waitrequest_in
);

  logic [1:0]        state_q, state_d;
  logic [IADDR-1:0]  base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  logic              buf_we;
  logic [IDX_W-1:0]  buf_widx;
  beat_t             buf_wbeat;
  beat_t             buf_rbeat;

  logic [IADDR-1:0]  next_addr;
  logic              append_ok;
  logic              buf_full;
  logic              timed_out;
  logic              last_beat;

  burst_beat_buffer u_buf (
    .clk_i     (clk_sys),
    .wr_en_i   (buf_we),
    .wr_idx_i  (buf_widx),
    .wr_beat_i (buf_wbeat),
    .rd_idx_i  (beat_q),
    .rd_beat_o (buf_rbeat)
  );

  // Read return path is a pure pass-through; ordering is guaranteed by flushing before reads.
  assign readdata_out      = readdata_in;
  assign readdatavalid_out = readdatavalid_in;

  assign buf_wbeat.data = writedata_in;
  assign buf_wbeat.be   = byteenable_in;

  // Address that would extend the current burst; wraps naturally in IADDR bits.
  assign next_addr = base_q + IADDR'(count_q) * IADDR'(WORD_BYTES);
  assign buf_full  = (count_q == CNT_W'(BURST_MAX));
  assign timed_out = (idle_cnt_q == IDLE_W'(TIMEOUT));
  assign last_beat = ({1'b0, beat_q} == (count_q - CNT_W'(1)));
  assign append_ok = write_in && !read_in && !buf_full
                  && (addr_in == next_addr)
                  && !is_line_head(addr_in[LINE_LSB-1:WORD_LSB]);

  // Next-state and downstream/upstream handshake decode.
  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    count_d         = count_q;
    beat_d          = beat_q;
    idle_cnt_d      = idle_cnt_q;
    buf_we          = 1'b0;
    buf_widx        = count_q[IDX_W-1:0];
    waitrequest_out = 1'b1;
    write_out       = 1'b0;
    read_out        = 1'b0;
    addr_out        = OADDR'(base_q);
    burstcount_out  = '0;
    writedata_out   = buf_rbeat.data;
    byteenable_out  = buf_rbeat.be;

    unique case (state_q)
      ST_IDLE: begin
        if (read_in) begin
          state_d = ST_READ;
        end else if (write_in) begin
          waitrequest_out = 1'b0;
          buf_we          = 1'b1;
          buf_widx        = '0;
          base_d          = addr_in;
          count_d         = CNT_W'(1);
          idle_cnt_d      = '0;
          state_d         = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (buf_full || read_in || timed_out || (write_in && !append_ok)) begin
          state_d = ST_FLUSH;
        end else if (write_in) begin
          waitrequest_out = 1'b0;
          buf_we          = 1'b1;
          count_d         = count_q + CNT_W'(1);
          idle_cnt_d      = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end

      ST_FLUSH: begin
        write_out      = 1'b1;
        burstcount_out = BCNT_W'(count_q);
        if (!waitrequest_in) begin
          if (last_beat) begin
            count_d    = '0;
            beat_d     = '0;
            idle_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            beat_d = beat_q + IDX_W'(1);
          end
        end
      end

      ST_READ: begin
        read_out        = 1'b1;
        addr_out        = OADDR'(addr_in);
        burstcount_out  = BCNT_W'(1);
        waitrequest_out = waitrequest_in;
        if (!waitrequest_in) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset blanks every request immediately, including a burst already in flight.
    if (rst) begin
      waitrequest_out = 1'b1;
      write_out       = 1'b0;
      read_out        = 1'b0;
      burstcount_out  = '0;
      buf_we          = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule
